// File: rtl/dso_pkg.sv
// Shared types and default sizes for the DSO capture path.
package dso_pkg;

    localparam int DSO_DW    = 8;
    localparam int DSO_AW    = 17;
    localparam int DSO_DEPTH = 10000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POSTFILL  = 3'd3,
        DONE      = 3'd4
    } cap_state_t;

    function automatic logic is_busy(input cap_state_t s);
        return (s == PREFILL) || (s == WAIT_TRIG) || (s == POSTFILL);
    endfunction

endpackage

// File: rtl/dso_trigger_detect.sv
// Level/slope crossing detector with auto-trigger timeout, evaluated on the
// sample being accepted this cycle.
module dso_trigger_detect
    import dso_pkg::*;
#(
    parameter int DW           = DSO_DW,
    parameter int AUTO_TIMEOUT = 50000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_accept,
    input  logic          i_in_wait,
    input  logic [DW-1:0] i_sample,
    input  logic [DW-1:0] i_trig_level,
    input  logic          i_trig_rising,
    input  logic          i_auto_mode,
    output logic          o_trig_hit,
    output logic          o_trig_is_forced
);

    localparam int            CW          = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CW-1:0] L_AUTO_LAST = CW'(AUTO_TIMEOUT - 1);

    logic [DW-1:0] r_prev;
    logic          r_prev_vld;
    logic [CW-1:0] r_auto_cnt;
    logic          w_cross;
    logic          w_timeout;

    // Crossing needs a previous sample from the same capture.
    always_comb begin
        w_cross = 1'b0;
        if (!r_prev_vld) begin
            w_cross = 1'b0;
        end else if (i_trig_rising) begin
            w_cross = (r_prev < i_trig_level) && (i_sample >= i_trig_level);
        end else begin
            w_cross = (r_prev > i_trig_level) && (i_sample <= i_trig_level);
        end
        w_timeout        = i_auto_mode && (r_auto_cnt == L_AUTO_LAST);
        o_trig_hit       = i_accept && i_in_wait && (w_cross || w_timeout);
        o_trig_is_forced = o_trig_hit && !w_cross;
    end

    // Counter saturates so a late switch to auto mode fires on the next sample.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_auto_cnt <= '0;
        end else if (i_clear) begin
            r_prev_vld <= 1'b0;
            r_auto_cnt <= '0;
        end else if (i_accept) begin
            r_prev     <= i_sample;
            r_prev_vld <= 1'b1;
            if (i_in_wait && (r_auto_cnt != L_AUTO_LAST)) begin
                r_auto_cnt <= r_auto_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dso_capture_sequencer.sv
// Trigger/capture sequencer: circular sample buffer in a single-port RAM,
// pre-trigger window freeze and trigger-relative readout.
module dso_capture_sequencer
    import dso_pkg::*;
#(
    parameter int DW           = DSO_DW,
    parameter int AW           = DSO_AW,
    parameter int DEPTH        = DSO_DEPTH,
    parameter int PRE_SAMPLES  = 5000,
    parameter int AUTO_TIMEOUT = 50000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_arm,
    input  logic          i_abort,
    input  logic [DW-1:0] i_trig_level,
    input  logic          i_trig_rising,
    input  logic          i_auto_mode,
    input  logic          i_sample_valid,
    input  logic [DW-1:0] i_sample,
    output logic          o_mem_cs,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_idx,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_trig_forced,
    output logic [AW-1:0] o_start_addr,
    output logic [AW-1:0] o_trig_addr
);

    localparam logic [AW-1:0] L_DEPTH_A   = AW'(DEPTH);
    localparam logic [AW-1:0] L_LAST_A    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] L_PRE_A     = AW'(PRE_SAMPLES);
    localparam logic [AW:0]   L_DEPTH_S   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] L_PRE_LAST  = AW'(PRE_SAMPLES - 1);
    localparam logic [AW-1:0] L_POST_LAST = AW'(DEPTH - PRE_SAMPLES - 2);

    cap_state_t    r_state;
    cap_state_t    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic [AW-1:0] r_wp;
    logic          r_busy;
    logic          r_done;
    logic          r_mem_cs;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_rd_pend;
    logic          r_rd_valid;
    logic          r_trig_forced;
    logic [AW-1:0] r_start_addr;
    logic [AW-1:0] r_trig_addr;

    logic          w_busy;
    logic          w_start;
    logic          w_accept;
    logic          w_rd_go;
    logic          w_trig_hit;
    logic          w_trig_is_forced;
    logic [AW-1:0] w_trig_start;
    logic [AW:0]   w_rd_sum;
    logic [AW-1:0] w_rd_addr;

    dso_trigger_detect #(
        .DW           (DW),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) u_trig (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_clear          (w_start || i_abort),
        .i_accept         (w_accept),
        .i_in_wait        (r_state == WAIT_TRIG),
        .i_sample         (i_sample),
        .i_trig_level     (i_trig_level),
        .i_trig_rising    (i_trig_rising),
        .i_auto_mode      (i_auto_mode),
        .o_trig_hit       (w_trig_hit),
        .o_trig_is_forced (w_trig_is_forced)
    );

    // Qualifiers and modulo address math; abort suppresses everything new.
    always_comb begin
        w_busy       = is_busy(r_state);
        w_start      = ((r_state == IDLE) || (r_state == DONE)) && i_arm && !i_abort;
        w_accept     = w_busy && i_sample_valid && !i_abort;
        w_rd_go      = (r_state == DONE) && i_rd_en && (i_rd_idx < L_DEPTH_A) && !i_abort;
        w_trig_start = (r_wp >= L_PRE_A) ? (r_wp - L_PRE_A) : (r_wp + (L_DEPTH_A - L_PRE_A));
        w_rd_sum     = {1'b0, r_start_addr} + {1'b0, i_rd_idx};
        w_rd_addr    = AW'((w_rd_sum >= L_DEPTH_S) ? (w_rd_sum - L_DEPTH_S) : w_rd_sum);
    end

    // Capture FSM next state and fill counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_arm) begin
                        w_state_nxt = PREFILL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                PREFILL: begin
                    if (w_accept && (r_cnt == L_PRE_LAST)) begin
                        w_state_nxt = WAIT_TRIG;
                        w_cnt_nxt   = '0;
                    end else if (w_accept) begin
                        w_cnt_nxt = r_cnt + AW'(1);
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                WAIT_TRIG: begin
                    if (w_trig_hit) begin
                        w_state_nxt = POSTFILL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                POSTFILL: begin
                    if (w_accept && (r_cnt == L_POST_LAST)) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else if (w_accept) begin
                        w_cnt_nxt = r_cnt + AW'(1);
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, RAM port mux (write and read are never live together), trigger capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_wp          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_cs      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rd_pend     <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_trig_forced <= 1'b0;
            r_start_addr  <= '0;
            r_trig_addr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= is_busy(w_state_nxt);
            r_done     <= (w_state_nxt == DONE);
            r_rd_pend  <= w_rd_go;
            r_rd_valid <= r_rd_pend;
            if (w_accept) begin
                r_mem_cs    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_wp;
                r_mem_wdata <= i_sample;
                r_wp        <= (r_wp == L_LAST_A) ? '0 : (r_wp + AW'(1));
            end else if (w_rd_go) begin
                r_mem_cs   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_rd_addr;
            end else begin
                r_mem_cs <= 1'b0;
                r_mem_we <= 1'b0;
            end
            if (w_trig_hit) begin
                r_trig_addr   <= r_wp;
                r_start_addr  <= w_trig_start;
                r_trig_forced <= w_trig_is_forced;
            end
        end
    end

    assign o_mem_cs      = r_mem_cs;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = i_mem_rdata;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_trig_forced = r_trig_forced;
    assign o_start_addr  = r_start_addr;
    assign o_trig_addr   = r_trig_addr;

endmodule

// File: tb/tb_dso_capture_sequencer.sv
// Scoreboard bench for dso_capture_sequencer with a small RAM model
// (DEPTH=16, PRE_SAMPLES=4, AUTO_TIMEOUT=8).
module tb_dso_capture_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 17;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int AUTO  = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm, abort, rising, auto_m, sv, rd_en;
    logic [DW-1:0] lvl, smp, rdata;
    logic [AW-1:0] rd_idx;
    logic          mem_cs, mem_we, rd_valid, busy, done, trig_forced;
    logic [AW-1:0] mem_addr, start_addr, trig_addr;
    logic [DW-1:0] mem_wdata, rd_data;

    logic [DW-1:0] ram    [0:DEPTH-1];
    logic [DW-1:0] shadow [0:DEPTH-1];
    acc_t          wr_q[$];
    acc_t          rda_q[$];
    acc_t          rdd_q[$];
    int            m_wp = 0;
    int            n_total = 0;
    int            n_bad = 0;

    dso_capture_sequencer #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .PRE_SAMPLES(PRE), .AUTO_TIMEOUT(AUTO)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_arm(arm), .i_abort(abort),
        .i_trig_level(lvl), .i_trig_rising(rising), .i_auto_mode(auto_m),
        .i_sample_valid(sv), .i_sample(smp),
        .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(rdata), .i_rd_en(rd_en), .i_rd_idx(rd_idx),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_busy(busy), .o_done(done),
        .o_trig_forced(trig_forced), .o_start_addr(start_addr), .o_trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
            else        rdata <= ram[mem_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: RAM writes, read addresses and read data in issue order.
    always @(negedge clk) begin
        acc_t e;
        if (!rst) begin
            if (mem_cs && mem_we) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 32'(1), 32'(0));
                else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (mem_cs && !mem_we) begin
                if (rda_q.size() == 0) chk("rd_addr_unexpected", 32'(1), 32'(0));
                else begin
                    e = rda_q.pop_front();
                    chk("rd_addr", 32'(mem_addr), 32'(e.addr));
                    rdd_q.push_back(e);
                end
            end
            if (rd_valid) begin
                if (rdd_q.size() == 0) chk("rd_valid_unexpected", 32'(1), 32'(0));
                else begin
                    e = rdd_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] s, input bit acc);
        sv  = 1'b1;
        smp = s;
        if (acc) begin
            wr_q.push_back('{addr: AW'(m_wp), data: s});
            shadow[m_wp] = s;
            m_wp = (m_wp + 1) % DEPTH;
        end
        step();
        sv = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        sv  = 1'b1;
        smp = 8'hEE;
        step();
        arm = 1'b0;
        sv  = 1'b0;
        chk("arm_busy", 32'(busy), 32'(1));
        chk("arm_done", 32'(done), 32'(0));
    endtask

    task automatic rd(input logic [AW-1:0] idx, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        rd_en  = 1'b1;
        rd_idx = idx;
        rda_q.push_back('{addr: ea, data: ed});
        step();
        rd_en = 1'b0;
    endtask

    task automatic prefill(input logic [DW-1:0] v);
        for (int k = 0; k < PRE; k++) begin
            send(v, 1'b1);
        end
        chk("prefill_busy", 32'(busy), 32'(1));
    endtask

    task automatic post_fill(input logic [DW-1:0] base, input logic [DW-1:0] stp);
        for (int k = 0; k < DEPTH - PRE - 1; k++) begin
            send(base + stp * DW'(k), 1'b1);
            if (k < DEPTH - PRE - 2) chk("post_done_early", 32'(done), 32'(0));
        end
        chk("post_done", 32'(done), 32'(1));
        chk("post_busy", 32'(busy), 32'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_cs"}, 32'(mem_cs), 32'(0));
        chk({tag, "_we"}, 32'(mem_we), 32'(0));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(0));
        chk({tag, "_rdv"}, 32'(rd_valid), 32'(0));
        chk({tag, "_forced"}, 32'(trig_forced), 32'(0));
        chk({tag, "_start"}, 32'(start_addr), 32'(0));
        chk({tag, "_trig"}, 32'(trig_addr), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int exp_t;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; rising = 1'b1; auto_m = 1'b0;
        sv = 1'b0; rd_en = 1'b0; lvl = 8'h80; smp = 8'h00; rd_idx = '0;
        step(); step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Trigger without wrap.
        do_arm();
        for (int k = 1; k <= 8; k++) send(DW'(k * 16), 1'b1);
        chk("t1_trig_addr", 32'(trig_addr), 32'(7));
        chk("t1_start_addr", 32'(start_addr), 32'(3));
        chk("t1_forced", 32'(trig_forced), 32'(0));
        post_fill(8'h90, 8'h10);
        send(8'h11, 1'b0);
        chk("t1_done_hold", 32'(done), 32'(1));
        rd(17'd4, 17'd7, 8'h80);
        rd(17'd0, 17'd3, 8'h40);
        rd(17'd15, 17'd2, shadow[2]);
        rd_en = 1'b1; rd_idx = 17'd16; step(); rd_en = 1'b0;
        step(); step(); step();

        // Crossing during prefill is ignored.
        do_arm();
        send(8'h70, 1'b1); send(8'h90, 1'b1); send(8'h90, 1'b1); send(8'h90, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send(8'h90, 1'b1);
            chk("t2_busy", 32'(busy), 32'(1));
            chk("t2_done", 32'(done), 32'(0));
        end
        chk("t2_trig_hold", 32'(trig_addr), 32'(7));
        send(8'h70, 1'b1);
        exp_t = m_wp;
        send(8'h90, 1'b1);
        chk("t2_trig_addr", 32'(trig_addr), 32'(exp_t));
        chk("t2_start_addr", 32'(start_addr), 32'((exp_t + DEPTH - PRE) % DEPTH));
        post_fill(8'h01, 8'h01);

        // Auto trigger on constant input.
        auto_m = 1'b1;
        do_arm();
        prefill(8'h00);
        for (int k = 0; k < AUTO - 1; k++) send(8'h00, 1'b1);
        chk("t3_not_yet", 32'(busy), 32'(1));
        chk("t3_forced_pre", 32'(trig_forced), 32'(0));
        exp_t = m_wp;
        send(8'h00, 1'b1);
        chk("t3_forced", 32'(trig_forced), 32'(1));
        chk("t3_trig_addr", 32'(trig_addr), 32'(exp_t));
        chk("t3_start_addr", 32'(start_addr), 32'((exp_t + DEPTH - PRE) % DEPTH));
        post_fill(8'h00, 8'h00);

        auto_m = 1'b0;
        do_arm();
        prefill(8'h00);
        for (int k = 0; k < 30; k++) send(8'h00, 1'b1);
        chk("t3_noauto_busy", 32'(busy), 32'(1));
        chk("t3_noauto_done", 32'(done), 32'(0));
        abort = 1'b1; step(); abort = 1'b0;
        chk("t3_abort_busy", 32'(busy), 32'(0));

        // Wrapped window: trigger at wp=1.
        do_arm();
        prefill(8'h00);
        for (int g = 0; g < 20 && m_wp != 1; g++) send(8'h00, 1'b1);
        send(8'h80, 1'b1);
        chk("t4_trig_addr", 32'(trig_addr), 32'(1));
        chk("t4_start_addr", 32'(start_addr), 32'(13));
        chk("t4_forced", 32'(trig_forced), 32'(0));
        post_fill(8'hC0, 8'h01);
        rd(17'd15, 17'd12, shadow[12]);
        rd(17'd3, 17'd0, shadow[0]);
        rd(17'd4, 17'd1, 8'h80);
        step(); step(); step();

        // Abort during postfill with a sample pending.
        do_arm();
        prefill(8'h00);
        send(8'h80, 1'b1);
        send(8'h33, 1'b1); send(8'h34, 1'b1);
        sv = 1'b1; smp = 8'h55; abort = 1'b1; step(); abort = 1'b0; sv = 1'b0;
        chk("ab_busy", 32'(busy), 32'(0));
        chk("ab_done", 32'(done), 32'(0));
        chk("ab_we", 32'(mem_we), 32'(0));
        chk("ab_cs", 32'(mem_cs), 32'(0));

        // arm and abort together, then read in IDLE.
        arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
        chk("armab_busy", 32'(busy), 32'(0));
        send(8'h66, 1'b0);
        chk("armab_we", 32'(mem_we), 32'(0));
        rd_en = 1'b1; rd_idx = '0; step(); rd_en = 1'b0;
        chk("idle_rd_cs", 32'(mem_cs), 32'(0));
        step();
        chk("idle_rd_valid", 32'(rd_valid), 32'(0));

        // Reset in the middle of postfill.
        do_arm();
        prefill(8'h00);
        send(8'h80, 1'b1);
        send(8'h21, 1'b1); send(8'h22, 1'b1);
        sv = 1'b1; smp = 8'h23;
        #2 rst = 1'b1;
        #1;
        chk_zero("midrst");
        sv = 1'b0;
        wr_q.delete();
        m_wp = 0;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(8'h44, 1'b0);
            chk("midrst_we", 32'(mem_we), 32'(0));
        end
        do_arm();
        send(8'h5A, 1'b1);
        step(); step();

        chk("wr_q_empty", 32'(wr_q.size()), 32'(0));
        chk("rda_q_empty", 32'(rda_q.size()), 32'(0));
        chk("rdd_q_empty", 32'(rdd_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
